cfg_reg_bank: RTL and testbench

CFG_REG_BANK -- requirements
Module: cfg_reg_bank

---
 rtl/cfg_reg_bank_if.sv | 27 ++
 rtl/cfg_reg_bank.sv | 129 ++++++++++++
 tb/tb_cfg_reg_bank.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cfg_reg_bank_if.sv
// Bus bundle for cfg_reg_bank: request side driven by the master,
// read data and status pulses returned by the slave.
interface cfg_reg_bank_if #(
    parameter int ADDR_WD = 4,
    parameter int DATA_WD = 16
);
    logic                 WrEn;
    logic                 RdEn;
    logic [ADDR_WD-1:0]   Address;
    logic [DATA_WD-1:0]   WrData;
    logic [DATA_WD/8-1:0] WrStrb;
    logic                 ClrReq;
    logic [DATA_WD-1:0]   RdData;
    logic                 RdValid;
    logic                 Err;
    logic                 Busy;

    modport master (
        output WrEn, RdEn, Address, WrData, WrStrb, ClrReq,
        input  RdData, RdValid, Err, Busy
    );

    modport slave (
        input  WrEn, RdEn, Address, WrData, WrStrb, ClrReq,
        output RdData, RdValid, Err, Busy
    );
endinterface

// File: rtl/cfg_reg_bank.sv
// Configuration register bank with byte-strobed writes, read-only masking,
// one-cycle registered reads and a sweep that restores all defaults.
module cfg_reg_bank #(
    parameter int                     ADDR_WD = 4,
    parameter int                     DATA_WD = 16,
    parameter int                     NUM_EXP = 4,
    parameter logic [2**ADDR_WD-1:0]  RO_MASK = '0
) (
    input  logic                       CLK,
    input  logic                       RST,
    cfg_reg_bank_if.slave              bus,
    output logic [NUM_EXP*DATA_WD-1:0] REG_EXP
);
    localparam int DEPTH = 2**ADDR_WD;
    localparam int LANES = DATA_WD / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    // Reg 2 = UART parity enabled/even, prescale 32; reg 3 = TX clock divide 32.
    function automatic logic [DATA_WD-1:0] default_val(input int idx);
        case (idx)
            2:       return DATA_WD'(8'h81);
            3:       return DATA_WD'(8'h20);
            default: return '0;
        endcase
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_WD:0]     r_sweep;
    logic [DATA_WD-1:0]   r_regs [DEPTH];
    logic [DATA_WD-1:0]   r_rd_data;
    logic                 r_rd_valid;
    logic                 r_err;
    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic                 w_err;
    logic                 w_clr_wr;
    logic                 w_sweep_last;

    assign w_sweep_last = (r_sweep == (ADDR_WD+1)'(DEPTH-1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.ClrReq) w_state_nxt = CLEAR;
            CLEAR:   if (w_sweep_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ClrReq wins over a same-cycle bus request; a zero strobe is a silent no-op.
    always_comb begin
        w_wr_ok  = 1'b0;
        w_rd_ok  = 1'b0;
        w_err    = 1'b0;
        w_clr_wr = 1'b0;
        case (r_state)
            IDLE: begin
                if (!bus.ClrReq) begin
                    if (bus.WrEn && bus.RdEn) begin
                        w_err = 1'b1;
                    end else if (bus.WrEn) begin
                        if (bus.WrStrb != '0) begin
                            if (RO_MASK[bus.Address]) w_err   = 1'b1;
                            else                      w_wr_ok = 1'b1;
                        end
                    end else if (bus.RdEn) begin
                        w_rd_ok = 1'b1;
                    end
                end
            end
            CLEAR: begin
                w_clr_wr = 1'b1;
                w_err    = bus.WrEn | bus.RdEn;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sweep <= '0;
        end else if (w_clr_wr) begin
            r_sweep <= w_sweep_last ? '0 : r_sweep + 1'b1;
        end
    end

    // NOTE: the storage is a small flop array that must come out of reset holding defaults, so it is reset asynchronously rather than left as an unreset RAM.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= default_val(i);
        end else if (w_clr_wr) begin
            r_regs[r_sweep[ADDR_WD-1:0]] <= default_val(int'(r_sweep));
        end else if (w_wr_ok) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.WrStrb[k]) r_regs[bus.Address][8*k +: 8] <= bus.WrData[8*k +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            r_err      <= w_err;
            if (w_rd_ok) r_rd_data <= r_regs[bus.Address];
        end
    end

    assign bus.RdData  = r_rd_data;
    assign bus.RdValid = r_rd_valid;
    assign bus.Err     = r_err;
    assign bus.Busy    = (r_state == CLEAR);

    for (genvar i = 0; i < NUM_EXP; i++) begin : g_exp
        assign REG_EXP[i*DATA_WD +: DATA_WD] = r_regs[i];
    end
endmodule

// File: tb/tb_cfg_reg_bank.sv
// Directed bench for cfg_reg_bank: reads, strobed writes, RO rejection,
// clear sweep timing and asynchronous reset in the middle of a sweep.
module tb_cfg_reg_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] reg_exp;
    int          n_total = 0;
    int          n_bad = 0;

    cfg_reg_bank_if #(.ADDR_WD(4), .DATA_WD(16)) bus ();

    cfg_reg_bank #(
        .ADDR_WD (4),
        .DATA_WD (16),
        .NUM_EXP (4),
        .RO_MASK (16'h0002)
    ) dut (
        .CLK     (clk),
        .RST     (rst_n),
        .bus     (bus),
        .REG_EXP (reg_exp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] def_val(input int idx);
        case (idx)
            2:       return 16'h0081;
            3:       return 16'h0020;
            default: return 16'h0000;
        endcase
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.WrEn = 1'b0; bus.RdEn = 1'b0; bus.ClrReq = 1'b0;
        bus.Address = '0; bus.WrData = '0; bus.WrStrb = '0;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [15:0] d, input logic [1:0] s);
        bus.WrEn = 1'b1; bus.Address = a; bus.WrData = d; bus.WrStrb = s;
        tick();
        idle_bus();
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [15:0] d, output logic v);
        bus.RdEn = 1'b1; bus.Address = a;
        tick();
        d = bus.RdData; v = bus.RdValid;
        idle_bus();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && bus.Busy; i++) tick();
        check("busy_timeout", bus.Busy, 1'b0);
    endtask

    logic [15:0] rd;
    logic        vl;
    int          busy_cnt;

    initial begin
        idle_bus();
        #23;
        check("rst_busy", bus.Busy, 1'b0);
        check("rst_rdvalid", bus.RdValid, 1'b0);
        check("rst_err", bus.Err, 1'b0);
        check("rst_rddata", bus.RdData, 16'h0);
        check("rst_exp", reg_exp, 64'h0020_0081_0000_0000);
        check("rst_exp_reg2", reg_exp[47:32], 16'h0081);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        read_reg(4'd2, rd, vl);
        check("rd2_data", rd, 16'h0081);
        check("rd2_valid", vl, 1'b1);
        tick();
        check("rd2_valid_drop", bus.RdValid, 1'b0);
        check("rd2_hold", bus.RdData, 16'h0081);
        read_reg(4'd3, rd, vl);
        check("rd3_data", rd, 16'h0020);
        check("rd3_valid", vl, 1'b1);
        tick();
        check("rd3_valid_drop", bus.RdValid, 1'b0);

        write_reg(4'd5, 16'h1234, 2'b11);
        write_reg(4'd5, 16'hABCD, 2'b01);
        check("strb01_err", bus.Err, 1'b0);
        read_reg(4'd5, rd, vl);
        check("strb01_data", rd, 16'h12CD);
        write_reg(4'd5, 16'hFFFF, 2'b00);
        check("strb00_err", bus.Err, 1'b0);
        read_reg(4'd5, rd, vl);
        check("strb00_data", rd, 16'h12CD);
        write_reg(4'd0, 16'h99AA, 2'b10);
        check("strb10_exp0", reg_exp[15:0], 16'h9900);

        write_reg(4'd1, 16'hFFFF, 2'b11);
        check("ro_err", bus.Err, 1'b1);
        tick();
        check("ro_err_drop", bus.Err, 1'b0);
        check("ro_exp1", reg_exp[31:16], 16'h0000);
        read_reg(4'd1, rd, vl);
        check("ro_data", rd, 16'h0000);

        bus.WrEn = 1'b1; bus.RdEn = 1'b1; bus.Address = 4'd5;
        bus.WrData = 16'h0F0F; bus.WrStrb = 2'b11;
        tick();
        idle_bus();
        check("both_err", bus.Err, 1'b1);
        check("both_rdvalid", bus.RdValid, 1'b0);
        read_reg(4'd5, rd, vl);
        check("both_nowrite", rd, 16'h12CD);

        for (int i = 0; i < 16; i++) write_reg(4'(i), 16'h5555, 2'b11);
        read_reg(4'd9, rd, vl);
        check("fill_rd9", rd, 16'h5555);
        check("fill_exp", reg_exp, 64'h5555_5555_0000_5555);

        bus.ClrReq = 1'b1;
        tick();
        idle_bus();
        check("clr_busy_rise", bus.Busy, 1'b1);
        busy_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            if (i == 3) begin bus.RdEn = 1'b1; bus.Address = 4'd9; end
            tick();
            if (i == 3) begin
                idle_bus();
                check("clr_rd_err", bus.Err, 1'b1);
                check("clr_rd_valid", bus.RdValid, 1'b0);
            end
            if (bus.Busy) busy_cnt++;
            else break;
        end
        check("clr_busy_cycles", busy_cnt, 16);
        check("clr_exp", reg_exp, 64'h0020_0081_0000_0000);
        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), rd, vl);
            check($sformatf("clr_rd%0d", i), rd, def_val(i));
        end

        write_reg(4'd9, 16'h5555, 2'b11);
        read_reg(4'd2, rd, vl);
        bus.ClrReq = 1'b1;
        tick();
        idle_bus();
        for (int i = 0; i < 7; i++) begin
            if (i == 6) bus.RdEn = 1'b1;
            tick();
            idle_bus();
        end
        check("pre_rst_err", bus.Err, 1'b1);
        check("pre_rst_busy", bus.Busy, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.Busy, 1'b0);
        check("mid_rst_err", bus.Err, 1'b0);
        check("mid_rst_rdvalid", bus.RdValid, 1'b0);
        check("mid_rst_rddata", bus.RdData, 16'h0);
        check("mid_rst_exp", reg_exp, 64'h0020_0081_0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", bus.Busy, 1'b0);
        read_reg(4'd9, rd, vl);
        check("post_rst_rd9", rd, 16'h0000);
        check("post_rst_valid", vl, 1'b1);

        bus.ClrReq = 1'b1; bus.WrEn = 1'b1; bus.Address = 4'd0;
        bus.WrData = 16'h7777; bus.WrStrb = 2'b11;
        tick();
        idle_bus();
        check("clr_wr_err", bus.Err, 1'b0);
        check("clr_wr_busy", bus.Busy, 1'b1);
        check("clr_wr_dropped", reg_exp[15:0], 16'h0000);
        wait_idle();
        read_reg(4'd0, rd, vl);
        check("clr_wr_rd0", rd, 16'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
